// File: rtl/and_reduce_stream.sv
// Folds each valid/ready packet of WIDTH-bit beats into one registered bitwise-AND result.
// Define AND_REDUCE_COUNT_EN to add the down_beats output carrying the saturated beat count.
module and_reduce_stream #(
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             down_err
`ifdef AND_REDUCE_COUNT_EN
    ,
    output logic [CNT_W-1:0] down_beats
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   down_data_q, down_data_d;
    logic               down_err_q, down_err_d;
`ifdef AND_REDUCE_COUNT_EN
    logic [CNT_W-1:0]   down_beats_q, down_beats_d;
`endif

    logic               beat_ok_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               err_inc_s;

    // Per-bit 2:1 mux: the data bit selects between 0 and the held accumulator bit.
    function automatic logic [WIDTH-1:0] and_mux(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] sel);
        logic [WIDTH-1:0] res;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = sel[i] ? acc[i] : 1'b0;
        end
        return res;
    endfunction

    // Next-state, accumulator and result-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        down_data_d = down_data_q;
        down_err_d  = down_err_q;
`ifdef AND_REDUCE_COUNT_EN
        down_beats_d = down_beats_q;
`endif
        up_ready    = (state_q != HOLD);
        down_valid  = (state_q == HOLD);
        beat_ok_s   = up_valid && up_ready;
        acc_next_s  = and_mux(acc_q, up_data);
        cnt_inc_s   = (cnt_q == CNT_W'(MAX_BEATS)) ? cnt_q : cnt_q + CNT_W'(1);
        err_inc_s   = err_q || (cnt_q == CNT_W'(MAX_BEATS));

        case (state_q)
            IDLE, ACCUM: begin
                if (beat_ok_s) begin
                    if (up_last) begin
                        // Result moves to the output registers; the working set restarts clean.
                        state_d     = HOLD;
                        down_data_d = acc_next_s;
                        down_err_d  = err_inc_s;
`ifdef AND_REDUCE_COUNT_EN
                        down_beats_d = cnt_inc_s;
`endif
                        acc_d       = {WIDTH{1'b1}};
                        cnt_d       = {CNT_W{1'b0}};
                        err_d       = 1'b0;
                    end else begin
                        state_d = ACCUM;
                        acc_d   = acc_next_s;
                        cnt_d   = cnt_inc_s;
                        err_d   = err_inc_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (down_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = {WIDTH{1'b1}};
                cnt_d   = {CNT_W{1'b0}};
                err_d   = 1'b0;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {WIDTH{1'b1}};
            cnt_q       <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            down_data_q <= {WIDTH{1'b1}};
            down_err_q  <= 1'b0;
`ifdef AND_REDUCE_COUNT_EN
            down_beats_q <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            down_data_q <= down_data_d;
            down_err_q  <= down_err_d;
`ifdef AND_REDUCE_COUNT_EN
            down_beats_q <= down_beats_d;
`endif
        end
    end

    assign down_data = down_data_q;
    assign down_err  = down_err_q;
`ifdef AND_REDUCE_COUNT_EN
    assign down_beats = down_beats_q;
`endif

endmodule
